// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction
// memory: FSM state encodings, read/write select encodings, default size.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Memory read/write select as seen by the byte-wide instruction memory.
    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    // Default instruction memory size in bytes (must be a multiple of 4).
    localparam int unsigned DEF_MEM_BYTES = 128;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader: takes 32-bit words over a valid/ready stream and
// writes each as four big-endian byte cells, holding the CPU in reset while a
// session is active. All outputs decode from registered state only.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  word_count
);

    // One past the last writable byte; reaching it ends the session.
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(MEM_BYTES);

    state_t      state, state_nx;
    logic [1:0]  k;          // byte index within the word being written
    logic [31:0] addr;       // byte address of the current word
    logic [31:0] word_q;     // word being written
    logic        last_q;     // current word was tagged as final
    logic        full_q;     // session ended because memory filled
    logic        ovf_q;
    logic [7:0]  cnt_q;
    logic        at_end;

    assign at_end = (addr + 32'd4) == END_ADDR;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mem_rw    = MEM_READ;
        mem_addr  = 32'd0;
        mem_wdata = 8'd0;
        cpu_hold  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nx = WRITE;
            end
            WRITE: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
                mem_rw   = MEM_WRITE;
                mem_addr = addr + {30'd0, k};
                // Big-endian byte lane: k = 0 carries bits 31:24.
                case (k)
                    2'd0: mem_wdata = word_q[31:24];
                    2'd1: mem_wdata = word_q[23:16];
                    2'd2: mem_wdata = word_q[15:8];
                    default: mem_wdata = word_q[7:0];
                endcase
                if (k == 2'd3) state_nx = (last_q || at_end) ? DONE : ACCEPT;
            end
            default: begin  // DONE
                cpu_hold = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: session setup, word capture, byte stepping and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= 2'd0;
            addr   <= BASE_ADDR;
            word_q <= 32'd0;
            last_q <= 1'b0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr   <= BASE_ADDR;
                        cnt_q  <= 8'd0;
                        ovf_q  <= 1'b0;
                        full_q <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        word_q <= in_word;
                        last_q <= in_last;
                        k      <= 2'd0;
                    end
                end
                WRITE: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        addr   <= addr + 32'd4;
                        cnt_q  <= cnt_q + 8'd1;
                        full_q <= at_end;
                    end
                end
                default: begin  // DONE
                    // A word offered after the memory filled is dropped but flagged.
                    if (full_q && in_valid) ovf_q <= 1'b1;
                end
            endcase
        end
    end

    assign overflow   = ovf_q;
    assign word_count = cnt_q;

endmodule
